mesm6_iobus: RTL and testbench

- Initiator side of the MESM-6 peripheral register bus (i_addr/i_rd/i_wr/i_wdata/o_rdata/o_done).
- Takes one CPU I/O request at a time, decodes the peripheral index, and issues a single-cycle rd/wr strobe to that peripheral.
- Waits for the peripheral's done, captures read data, and returns a one-cycle completion to the CPU.
- Guards against unresponsive or nonexistent peripherals with a timeout and an error flag.

---
 rtl/mesm6_defines.sv | 16 +
 rtl/mesm6_iobus.sv | 129 ++++++++++++
 tb/tb_mesm6_iobus.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mesm6_defines.sv
// Shared MESM-6 definitions: data word width, I/O bus address decode
// position and the I/O bus initiator state encoding.
package mesm6_defines;

    localparam int WORD_W     = 48;
    localparam int IO_SEL_LSB = 3;
    localparam int IO_IDX_W   = 3;

    typedef enum logic [1:0] {
        IO_IDLE,
        IO_STROBE,
        IO_WAIT,
        IO_RESP
    } iobus_state_t;

endpackage

// File: rtl/mesm6_iobus.sv
// Initiator side of the MESM-6 peripheral register bus: one CPU request at a
// time, single-cycle strobe to the addressed peripheral, done/timeout handling.
module mesm6_iobus
    import mesm6_defines::*;
#(
    parameter int NPERIPH = 4,
    parameter int TIMEOUT = 15,
    parameter int SEL_LSB = IO_SEL_LSB
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [14:0]               cpu_addr,
    input  logic [WORD_W-1:0]         cpu_wdata,
    output logic                      cpu_ready,
    output logic                      cpu_done,
    output logic [WORD_W-1:0]         cpu_rdata,
    output logic                      cpu_err,
    output logic [14:0]               p_addr,
    output logic [WORD_W-1:0]         p_wdata,
    output logic [NPERIPH-1:0]        p_rd,
    output logic [NPERIPH-1:0]        p_wr,
    input  logic [WORD_W*NPERIPH-1:0] p_rdata,
    input  logic [NPERIPH-1:0]        p_done
);

    localparam int              TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [IO_IDX_W:0] NP   = 4'(NPERIPH);

    iobus_state_t          state;
    logic [TW-1:0]         timer;
    logic                  we_q;
    logic [IO_IDX_W-1:0]   idx_q;
    logic [IO_IDX_W-1:0]   idx_in;
    logic                  idx_bad;
    logic [NPERIPH-1:0]    sel_onehot;
    logic                  sel_done;
    logic [WORD_W-1:0]     sel_rdata;

    assign idx_in  = cpu_addr[SEL_LSB+IO_IDX_W-1:SEL_LSB];
    assign idx_bad = {1'b0, idx_in} >= NP;

    // Strobe decode uses the incoming index; done/rdata select use the latched one
    always_comb begin
        sel_onehot = '0;
        sel_done   = 1'b0;
        sel_rdata  = '0;
        for (int k = 0; k < NPERIPH; k++) begin
            sel_onehot[k] = (idx_in == IO_IDX_W'(k));
            if (idx_q == IO_IDX_W'(k)) begin
                sel_done  = p_done[k];
                sel_rdata = p_rdata[k*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IO_IDLE;
            timer     <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            cpu_ready <= 1'b1;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            p_addr    <= '0;
            p_wdata   <= '0;
            p_rd      <= '0;
            p_wr      <= '0;
        end else begin
            case (state)
                IO_IDLE: begin
                    if (cpu_req && cpu_ready) begin
                        p_addr    <= cpu_addr;
                        p_wdata   <= cpu_wdata;
                        we_q      <= cpu_we;
                        idx_q     <= idx_in;
                        cpu_ready <= 1'b0;
                        if (idx_bad) begin
                            cpu_done  <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= '0;
                            state     <= IO_RESP;
                        end else begin
                            if (cpu_we)
                                p_wr <= sel_onehot;
                            else
                                p_rd <= sel_onehot;
                            state <= IO_STROBE;
                        end
                    end
                end
                // Strobe is held for one cycle only: peripheral writes have side effects
                IO_STROBE: begin
                    p_rd  <= '0;
                    p_wr  <= '0;
                    timer <= '0;
                    state <= IO_WAIT;
                end
                IO_WAIT: begin
                    if (sel_done) begin
                        cpu_rdata <= we_q ? '0 : sel_rdata;
                        cpu_err   <= 1'b0;
                        cpu_done  <= 1'b1;
                        state     <= IO_RESP;
                    end else if (timer == T_LAST) begin
                        cpu_rdata <= '0;
                        cpu_err   <= 1'b1;
                        cpu_done  <= 1'b1;
                        state     <= IO_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                IO_RESP: begin
                    cpu_done  <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_ready <= 1'b1;
                    state     <= IO_IDLE;
                end
                default: state <= IO_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesm6_iobus.sv
// Directed self-checking bench for mesm6_iobus with a simple peripheral model
// that answers one cycle after each strobe unless silenced.
module tb_mesm6_iobus;

    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [14:0]       cpu_addr;
    logic [47:0]       cpu_wdata;
    logic              cpu_ready;
    logic              cpu_done;
    logic [47:0]       cpu_rdata;
    logic              cpu_err;
    logic [14:0]       p_addr;
    logic [47:0]       p_wdata;
    logic [NP-1:0]     p_rd;
    logic [NP-1:0]     p_wr;
    logic [48*NP-1:0]  p_rdata;
    logic [NP-1:0]     p_done;

    logic [NP-1:0]     resp_mask;
    logic [NP-1:0]     resp_q;
    logic [NP-1:0]     inj;
    int                strobe_total;
    int                done_total;
    logic [7:0]        last_strobe;
    int                vectors;
    int                miscompares;

    mesm6_iobus #(.NPERIPH(NP), .TIMEOUT(15), .SEL_LSB(3)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_rd(p_rd), .p_wr(p_wr),
        .p_rdata(p_rdata), .p_done(p_done)
    );

    always #5 clk = ~clk;

    assign p_rdata = {48'o5555, 48'o1234, 48'o4321, 48'o7070};
    assign p_done  = resp_q | inj;

    always @(posedge clk) resp_q <= (p_rd | p_wr) & resp_mask;

    // Free-running observers sampled exactly at the clock edge
    always @(posedge clk) begin
        if ((p_rd | p_wr) != '0) begin
            strobe_total = strobe_total + 1;
            last_strobe  = {p_rd, p_wr};
        end
        if (cpu_done) done_total = done_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    // Present a request and return at the observation point of cycle 1
    task automatic applyStimulus(input logic we, input logic [14:0] addr, input logic [47:0] wdata);
        int n;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        n = 0;
        while (!cpu_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic runTx(input string tag, input logic we, input logic [14:0] addr,
                         input logic [47:0] wdata, input int exp_cyc, input logic exp_err,
                         input logic [47:0] exp_rdata, input int exp_strobes,
                         input logic [7:0] exp_last, input logic [NP-1:0] inj_vec, input int inj_cyc);
        int s0;
        int cyc;
        s0 = strobe_total;
        applyStimulus(we, addr, wdata);
        checkOutput({tag, ".p_addr"}, 64'(p_addr), 64'(addr));
        checkOutput({tag, ".p_wdata"}, 64'(p_wdata), 64'(wdata));
        cyc = 1;
        forever begin
            inj = (cyc == inj_cyc) ? inj_vec : '0;
            if (cpu_done || cyc >= 40) break;
            tick();
            cyc++;
        end
        inj = '0;
        checkOutput({tag, ".done_cycle"}, 64'(cyc), 64'(exp_cyc));
        checkOutput({tag, ".done"}, 64'(cpu_done), 64'(1));
        checkOutput({tag, ".err"}, 64'(cpu_err), 64'(exp_err));
        checkOutput({tag, ".rdata"}, 64'(cpu_rdata), 64'(exp_rdata));
        tick();
        checkOutput({tag, ".done_fall"}, 64'(cpu_done), 64'(0));
        checkOutput({tag, ".err_fall"}, 64'(cpu_err), 64'(0));
        checkOutput({tag, ".ready"}, 64'(cpu_ready), 64'(1));
        checkOutput({tag, ".strobes"}, 64'(strobe_total - s0), 64'(exp_strobes));
        if (exp_strobes != 0)
            checkOutput({tag, ".strobe_vec"}, 64'(last_strobe), 64'(exp_last));
    endtask

    initial begin
        int d0;
        int s0;
        logic [15:0] done_mask;
        logic [15:0] ready_mask;

        vectors      = 0;
        miscompares  = 0;
        strobe_total = 0;
        done_total   = 0;
        last_strobe  = '0;
        resp_mask    = '1;
        inj          = '0;
        reset        = 1'b1;
        cpu_req      = 1'b0;
        cpu_we       = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        repeat (3) tick();

        checkOutput("reset.ready", 64'(cpu_ready), 64'(1));
        checkOutput("reset.done", 64'(cpu_done), 64'(0));
        checkOutput("reset.err", 64'(cpu_err), 64'(0));
        checkOutput("reset.rdata", 64'(cpu_rdata), 64'(0));
        checkOutput("reset.p_addr", 64'(p_addr), 64'(0));
        checkOutput("reset.strobes", 64'({p_rd, p_wr}), 64'(0));
        reset = 1'b0;
        tick();

        runTx("wr_idx0", 1'b1, 15'o05, 48'd1, 3, 1'b0, 48'd0, 1, 8'b0000_0001, '0, 0);
        runTx("rd_idx2", 1'b0, 15'o26, 48'd0, 3, 1'b0, 48'o1234, 1, 8'b0100_0000, '0, 0);

        // Silent peripheral 3: timeout, then a late done must be ignored
        resp_mask = 4'b0111;
        runTx("rd_timeout", 1'b0, 15'o30, 48'd0, 17, 1'b1, 48'd0, 1, 8'b1000_0000, '0, 0);
        d0 = done_total;
        inj = 4'b1000;
        tick();
        inj = '0;
        repeat (4) tick();
        checkOutput("late_done_ignored", 64'(done_total - d0), 64'(0));

        // Done arriving on the final timeout cycle wins
        runTx("rd_done_at_limit", 1'b0, 15'o31, 48'd0, 17, 1'b0, 48'o5555, 1, 8'b1000_0000, 4'b1000, 16);
        resp_mask = '1;

        runTx("bad_idx5", 1'b1, 15'o50, 48'd7, 1, 1'b1, 48'd0, 0, 8'b0, '0, 0);

        // Silent peripheral 0 with a stray done from peripheral 1 during WAIT
        resp_mask = 4'b1110;
        runTx("stray_done", 1'b0, 15'o03, 48'd0, 17, 1'b1, 48'd0, 1, 8'b0001_0000, 4'b0010, 2);
        resp_mask = '1;

        // Reset in cycle 2 of a read aborts it
        d0 = done_total;
        applyStimulus(1'b0, 15'o10, 48'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_mid.done", 64'(cpu_done), 64'(0));
        checkOutput("rst_mid.strobes", 64'({p_rd, p_wr}), 64'(0));
        checkOutput("rst_mid.ready", 64'(cpu_ready), 64'(1));
        repeat (4) tick();
        checkOutput("rst_mid.no_done", 64'(done_total - d0), 64'(0));
        runTx("wr_after_rst", 1'b1, 15'o11, 48'o777, 3, 1'b0, 48'd0, 1, 8'b0000_0010, '0, 0);

        // Back-to-back writes with the request held high
        s0         = strobe_total;
        done_mask  = '0;
        ready_mask = '0;
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 15'o02;
        cpu_wdata  = 48'd1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            done_mask[c]  = cpu_done;
            ready_mask[c] = cpu_ready;
            if (c == 1) begin
                cpu_addr  = 15'o12;
                cpu_wdata = 48'd2;
            end
            if (c == 5) begin
                cpu_req = 1'b0;
                checkOutput("b2b.p_addr2", 64'(p_addr), 64'(15'o12));
            end
            tick();
        end
        checkOutput("b2b.done_cycles", 64'(done_mask), 64'(16'b0000_0000_1000_1000));
        checkOutput("b2b.ready_cycles", 64'(ready_mask), 64'(16'b0000_0001_0001_0000));
        checkOutput("b2b.strobes", 64'(strobe_total - s0), 64'(2));
        checkOutput("b2b.last_strobe", 64'(last_strobe), 64'(8'b0000_0010));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
